pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_supervisor_pkg.sv | 20 ++
 rtl/sync_bit.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 130 +++++++++++++
 tb/tb_pll_lock_supervisor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared types and default constants for the PLL lock supervisor.
// The FSM state encoding is visible on state_o, so the enum values are fixed.
package pll_supervisor_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK  = 2'd0,
      STABILIZE  = 2'd1,
      HOLD_RESET = 2'd2,
      RUN        = 2'd3
   } state_t;

   localparam int DEF_SYNC_STAGES        = 2;
   localparam int DEF_LOCK_STABLE_CYCLES = 7200;
   localparam int DEF_RESET_HOLD_CYCLES  = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous level signal.
// Every flop clears on the asynchronous active-low reset.
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL lock indicator, sequences sys_reset_n, and keeps
// sticky lock-loss diagnostics for lock drops seen while running.
module pll_lock_supervisor
   import pll_supervisor_pkg::*;
#(
   parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       locked,
   input  logic       clear_flags,
   output logic       sys_reset_n,
   output logic       ready,
   output logic       lock_lost,
   output logic [7:0] lock_loss_count,
   output logic [1:0] state_o
);

   localparam int CNT_W = $clog2(max_int(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
   localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic             locked_s;
   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             loss_event;

   sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (locked),
      .q       (locked_s)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= WAIT_LOCK;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   // The cycle that moves WAIT_LOCK to STABILIZE is itself the first
   // qualified lock cycle, so the counter is loaded with one on entry.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      loss_event = 1'b0;
      case (state)
         WAIT_LOCK: begin
            cnt_n = '0;
            if (locked_s) begin
               state_n = STABILIZE;
               cnt_n   = CNT_ONE;
            end
         end
         STABILIZE: begin
            if (!locked_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt >= STAB_LAST) begin
               state_n = HOLD_RESET;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         HOLD_RESET: begin
            if (!locked_s) begin
               state_n = WAIT_LOCK;
               cnt_n   = '0;
            end else if (cnt >= HOLD_LAST) begin
               state_n = RUN;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         RUN: begin
            cnt_n = '0;
            if (!locked_s) begin
               state_n    = WAIT_LOCK;
               loss_event = 1'b1;
            end
         end
         default: begin
            state_n = WAIT_LOCK;
            cnt_n   = '0;
         end
      endcase
   end

   // Outputs follow the next state so they change on the same edge as the FSM.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sys_reset_n <= 1'b0;
         ready       <= 1'b0;
      end else begin
         sys_reset_n <= (state_n == RUN);
         ready       <= (state_n == RUN);
      end
   end

   // A loss event outranks a simultaneous clear: the clear empties the
   // history first, then the new loss is recorded.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         lock_lost       <= 1'b0;
         lock_loss_count <= 8'd0;
      end else if (loss_event) begin
         lock_lost <= 1'b1;
         if (clear_flags) begin
            lock_loss_count <= 8'd1;
         end else if (lock_loss_count != 8'hFF) begin
            lock_loss_count <= lock_loss_count + 8'd1;
         end
      end else if (clear_flags) begin
         lock_lost       <= 1'b0;
         lock_loss_count <= 8'd0;
      end
   end

   assign state_o = state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor with short qualification
// parameters (2 sync stages, 8 stable cycles, 4 hold cycles).
module tb_pll_lock_supervisor;

   localparam int S = 2;
   localparam int L = 8;
   localparam int H = 4;

   logic       clock;
   logic       reset_n;
   logic       locked;
   logic       clear_flags;
   logic       sys_reset_n;
   logic       ready;
   logic       lock_lost;
   logic [7:0] lock_loss_count;
   logic [1:0] state_o;

   int total;
   int bad;

   logic [12:0] exp_q[$];

   typedef struct {
      logic        locked;
      logic        clear;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl[16];

   pll_lock_supervisor #(
      .SYNC_STAGES        (S),
      .LOCK_STABLE_CYCLES (L),
      .RESET_HOLD_CYCLES  (H)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .locked          (locked),
      .clear_flags     (clear_flags),
      .sys_reset_n     (sys_reset_n),
      .ready           (ready),
      .lock_lost       (lock_lost),
      .lock_loss_count (lock_loss_count),
      .state_o         (state_o)
   );

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Expected state on edge e counted from the first edge after locked rises
   // into an all-zero synchronizer.
   function automatic logic [1:0] model_state(input int e);
      if (e <= S) return 2'd0;
      else if (e < S + L) return 2'd1;
      else if (e < S + L + H) return 2'd2;
      else return 2'd3;
   endfunction

   function automatic logic [12:0] mk(input logic [1:0] st, input logic lost,
                                      input logic [7:0] cnt);
      logic run;
      run = (st == 2'd3);
      return {st, run, run, lost, cnt};
   endfunction

   task automatic check_vec(input string name, input logic [12:0] got,
                            input logic [12:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got st=%0d srn=%0b rdy=%0b lost=%0b cnt=%0d, want st=%0d srn=%0b rdy=%0b lost=%0b cnt=%0d",
                  name, got[12:11], got[10], got[9], got[8], got[7:0],
                  want[12:11], want[10], want[9], want[8], want[7:0]);
      end
   endtask

   // driver + scoreboard: drive one cycle, push expectation, compare after edge
   task automatic step(input string name, input logic l, input logic c,
                       input logic [12:0] exp);
      logic [12:0] want;
      locked      = l;
      clear_flags = c;
      exp_q.push_back(exp);
      @(posedge clock);
      #1;
      want = exp_q.pop_front();
      check_vec(name, {state_o, sys_reset_n, ready, lock_lost, lock_loss_count}, want);
   endtask

   task automatic run_qual(input string name, input int first, input int last,
                           input logic lost, input logic [7:0] cnt);
      for (int e = first; e <= last; e++) begin
         step(name, 1'b1, 1'b0, mk(model_state(e), lost, cnt));
      end
   endtask

   // Drop lock for three cycles out of RUN, then requalify.
   task automatic lose_and_relock(input string name, input logic lost_before,
                                  input logic [7:0] cnt_before, input logic clr,
                                  input logic [7:0] cnt_after);
      step(name, 1'b0, 1'b0, mk(2'd3, lost_before, cnt_before));
      step(name, 1'b0, 1'b0, mk(2'd3, lost_before, cnt_before));
      step(name, 1'b0, clr, mk(2'd0, 1'b1, cnt_after));
      run_qual(name, 1, S + L + H, 1'b1, cnt_after);
   endtask

   task automatic do_reset();
      reset_n     = 1'b0;
      locked      = 1'b0;
      clear_flags = 1'b0;
      #1;
      check_vec("reset_state", {state_o, sys_reset_n, ready, lock_lost, lock_loss_count}, 13'd0);
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
      locked  = 1'b1;
   endtask

   initial begin
      int n;
      logic [7:0] c;
      total = 0;
      bad   = 0;

      for (int i = 0; i < 16; i++) begin
         tbl[i].locked = 1'b1;
         tbl[i].clear  = 1'b0;
         tbl[i].exp    = mk(model_state(i + 1), 1'b0, 8'd0);
      end

      // reset release with locked steady: RUN on edge S+L+H
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step($sformatf("qual_edge%0d", i + 1), tbl[i].locked, tbl[i].clear, tbl[i].exp);
      end

      // lock loss in RUN, then requalification
      lose_and_relock("run_loss", 1'b0, 8'd0, 1'b0, 8'd1);

      // clear alone: flags cleared, FSM untouched
      step("clear_alone", 1'b1, 1'b1, mk(2'd3, 1'b0, 8'd0));

      // build count to 5, then loss coinciding with clear
      for (int i = 0; i < 5; i++) begin
         lose_and_relock("count_up", (i != 0), 8'(i), 1'b0, 8'(i + 1));
      end
      lose_and_relock("loss_with_clear", 1'b1, 8'd5, 1'b1, 8'd1);
      step("clear_after", 1'b1, 1'b1, mk(2'd3, 1'b0, 8'd0));

      // 300 losses saturate the counter at 255
      c = 8'd0;
      for (int i = 1; i <= 300; i++) begin
         n = (i > 255) ? 255 : i;
         lose_and_relock("saturate", (i != 1), c, 1'b0, 8'(n));
         c = 8'(n);
      end
      step("sat_hold", 1'b1, 1'b0, mk(2'd3, 1'b1, 8'd255));

      // asynchronous reset between edges mid-RUN
      #3;
      reset_n = 1'b0;
      #1;
      check_vec("async_reset", {state_o, sys_reset_n, ready, lock_lost, lock_loss_count}, 13'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      run_qual("after_reset", 1, S + L + H, 1'b0, 8'd0);

      // one-cycle lock glitch during STABILIZE: back to WAIT_LOCK, no loss
      do_reset();
      run_qual("glitch_pre", 1, 5, 1'b0, 8'd0);
      step("glitch_e6", 1'b0, 1'b0, mk(2'd1, 1'b0, 8'd0));
      step("glitch_e7", 1'b1, 1'b0, mk(2'd1, 1'b0, 8'd0));
      run_qual("glitch_requal", 2, S + L + H, 1'b0, 8'd0);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
